telemetry_tx: RTL and testbench

- Periodic telemetry transmitter on the eBike's TX pin.
- Snapshots battery voltage, average motor current and average pedal torque, then serialises them as an 8-byte framed packet over an integrated 8N1 UART transmitter.
- It is the sending end that the bench's UART receiver decodes; it sits at the top level of eBike, fed by the A2D interface and sensorCondition outputs.

---
 rtl/telemetry_tx.sv | 165 ++++++++++++++++
 tb/tb_telemetry_tx.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/telemetry_tx.sv
// Periodic telemetry packet transmitter: snapshots battery voltage, motor current and
// pedal torque and sends them as an 8-byte framed packet over an 8N1 UART.
module telemetry_tx #(
  parameter int unsigned BAUD_DIV    = 2604,
  parameter int unsigned PERIOD_BITS = 20
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [11:0] batt_v,
  input  logic [11:0] avg_curr,
  input  logic [11:0] avg_torque,
  output logic        TX,
  output logic        busy,
  output logic        pkt_done
);

  localparam int unsigned BAUD_W = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
  localparam int unsigned SNAP_W = 36;
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(BAUD_DIV - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_e;

  state_e                 state_q, state_d;
  logic [PERIOD_BITS-1:0] period_q, period_d;
  logic [BAUD_W-1:0]      baud_q, baud_d;
  logic [2:0]             bit_q, bit_d;
  logic [2:0]             byte_q, byte_d;
  logic [SNAP_W-1:0]      snap_q, snap_d;
  logic                   tx_q, tx_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;

  logic                   trigger_c;
  logic                   bit_end_c;
  logic [2:0]             next_bit_c;
  logic [7:0]             cur_byte_c;

  assign trigger_c  = &period_q;
  assign bit_end_c  = (baud_q == BAUD_LAST);
  assign next_bit_c = bit_q + 3'd1;

  // Packet byte selected by byte index; payload bytes come only from the snapshot.
  always_comb begin
    cur_byte_c = 8'hAA;
    case (byte_q)
      3'd0:    cur_byte_c = 8'hAA;
      3'd1:    cur_byte_c = 8'h55;
      3'd2:    cur_byte_c = {4'h0, snap_q[35:32]};
      3'd3:    cur_byte_c = snap_q[31:24];
      3'd4:    cur_byte_c = {4'h0, snap_q[23:20]};
      3'd5:    cur_byte_c = snap_q[19:12];
      3'd6:    cur_byte_c = {4'h0, snap_q[11:8]};
      default: cur_byte_c = snap_q[7:0];
    endcase
  end

  // Next-state logic; TX/busy/pkt_done are computed one cycle ahead and registered.
  always_comb begin
    state_d  = state_q;
    period_d = period_q + PERIOD_BITS'(1);
    baud_d   = baud_q;
    bit_d    = bit_q;
    byte_d   = byte_q;
    snap_d   = snap_q;
    tx_d     = tx_q;
    busy_d   = busy_q;
    done_d   = 1'b0;

    case (state_q)
      IDLE: begin
        tx_d   = 1'b1;
        busy_d = 1'b0;
        if (trigger_c) begin
          snap_d  = {batt_v, avg_curr, avg_torque};
          state_d = START;
          baud_d  = '0;
          byte_d  = 3'd0;
          tx_d    = 1'b0;
          busy_d  = 1'b1;
        end
      end
      START: begin
        if (bit_end_c) begin
          baud_d  = '0;
          bit_d   = 3'd0;
          state_d = DATA;
          tx_d    = cur_byte_c[0];
        end else begin
          baud_d = baud_q + BAUD_W'(1);
        end
      end
      DATA: begin
        if (bit_end_c) begin
          baud_d = '0;
          if (bit_q == 3'd7) begin
            state_d = STOP;
            tx_d    = 1'b1;
          end else begin
            bit_d = next_bit_c;
            tx_d  = cur_byte_c[next_bit_c];
          end
        end else begin
          baud_d = baud_q + BAUD_W'(1);
        end
      end
      STOP: begin
        if (bit_end_c) begin
          baud_d = '0;
          if (byte_q == 3'd7) begin
            state_d = IDLE;
            byte_d  = 3'd0;
            tx_d    = 1'b1;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end else begin
            byte_d  = byte_q + 3'd1;
            state_d = START;
            tx_d    = 1'b0;
          end
        end else begin
          baud_d = baud_q + BAUD_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        tx_d    = 1'b1;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      period_q <= '0;
      baud_q   <= '0;
      bit_q    <= 3'd0;
      byte_q   <= 3'd0;
      snap_q   <= '0;
      tx_q     <= 1'b1;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      period_q <= period_d;
      baud_q   <= baud_d;
      bit_q    <= bit_d;
      byte_q   <= byte_d;
      snap_q   <= snap_d;
      tx_q     <= tx_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign TX       = tx_q;
  assign busy     = busy_q;
  assign pkt_done = done_q;

endmodule

// File: tb/tb_telemetry_tx.sv
// Bench for telemetry_tx: UART receiver checks bytes against an expected-byte queue,
// plus timing checks for start delay, bit runs, packet length, dropped triggers and reset abort.
module tb_telemetry_tx;

  localparam int unsigned BAUD = 16;

  typedef struct {
    logic [11:0] batt;
    logic [11:0] curr;
    logic [11:0] torq;
    logic [63:0] bytes;
  } pkt_vec_t;

  logic        clk = 1'b0;
  logic        rst, rst2;
  logic [11:0] batt_v, avg_curr, avg_torque;
  logic        TX, busy, pkt_done;
  logic        TX2, busy2, pkt_done2;
  logic        sel;
  logic        rx_line, rx_rst;

  int          n_cmp = 0;
  int          n_bad = 0;
  int          cyc = 0;
  int          rst_ev = 0;
  int          done_cnt = 0;
  int          done2_cnt = 0;
  logic [7:0]  exp_q[$];
  pkt_vec_t    vecs[4];
  int          run_exp[9] = '{32, 16, 16, 16, 16, 16, 16, 32, 16};

  telemetry_tx #(.BAUD_DIV(BAUD), .PERIOD_BITS(12)) u_dut (
    .clk(clk), .rst(rst), .batt_v(batt_v), .avg_curr(avg_curr), .avg_torque(avg_torque),
    .TX(TX), .busy(busy), .pkt_done(pkt_done));

  telemetry_tx #(.BAUD_DIV(BAUD), .PERIOD_BITS(10)) u_drop (
    .clk(clk), .rst(rst2), .batt_v(batt_v), .avg_curr(avg_curr), .avg_torque(avg_torque),
    .TX(TX2), .busy(busy2), .pkt_done(pkt_done2));

  always #5 clk = ~clk;

  assign rx_line = sel ? TX2 : TX;
  assign rx_rst  = sel ? rst2 : rst;

  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge rst or posedge rst2) rst_ev <= rst_ev + 1;
  always @(negedge clk) begin
    if (pkt_done)  done_cnt  <= done_cnt + 1;
    if (pkt_done2) done2_cnt <= done2_cnt + 1;
  end

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
    end
  endtask

  task automatic push_pkt(input pkt_vec_t v);
    for (int i = 0; i < 8; i++) exp_q.push_back(v.bytes[63 - 8*i -: 8]);
  endtask

  task automatic apply_inputs(input pkt_vec_t v);
    batt_v     = v.batt;
    avg_curr   = v.curr;
    avg_torque = v.torq;
  endtask

  task automatic timeout(input string name);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: wait bound expired", name);
  endtask

  task automatic wait_tx_low(input int bound, output int at);
    int n;
    n = 0;
    while (TX !== 1'b0 && n <= bound) begin
      @(negedge clk);
      n++;
    end
    if (n > bound) timeout("wait_tx_low");
    at = cyc;
  endtask

  task automatic wait_done(input int bound, output int at);
    int n;
    n = 0;
    while (pkt_done !== 1'b1 && n <= bound) begin
      @(negedge clk);
      n++;
    end
    if (n > bound) timeout("wait_pkt_done");
    at = cyc;
  endtask

  // UART receiver: samples mid-bit; frames overlapping a reset are discarded.
  initial begin : uart_rx
    logic [9:0] frame;
    logic [7:0] e;
    int         ev;
    forever begin
      @(negedge clk);
      if (rx_rst === 1'b1 || rx_line !== 1'b0) continue;
      ev = rst_ev;
      repeat (BAUD/2) @(negedge clk);
      frame[0] = rx_line;
      for (int i = 1; i < 10; i++) begin
        repeat (BAUD) @(negedge clk);
        frame[i] = rx_line;
      end
      if (ev != rst_ev || rx_rst === 1'b1) continue;
      if (exp_q.size() == 0) begin
        timeout("rx_unexpected_byte");
      end else begin
        e = exp_q.pop_front();
        check("rx_frame", 64'(frame), 64'({1'b1, e, 1'b0}));
      end
    end
  end

  initial begin : watchdog
    #(60000 * 10);
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int t0, t1, t2, td, r, dc, lvl, len, prev;
    int starts[$];

    vecs[0] = '{12'hABC, 12'h123, 12'h7FF, 64'hAA55_0ABC_0123_07FF};
    vecs[1] = '{12'h000, 12'h123, 12'h7FF, 64'hAA55_0000_0123_07FF};
    vecs[2] = '{12'h5A5, 12'hF0F, 12'h001, 64'hAA55_05A5_0F0F_0001};
    vecs[3] = '{12'hFFF, 12'h800, 12'h0C3, 64'hAA55_0FFF_0800_00C3};

    sel  = 1'b0;
    rst  = 1'b1;
    rst2 = 1'b1;
    apply_inputs(vecs[0]);
    repeat (5) @(posedge clk);
    @(negedge clk);
    check("rst_tx", 64'(TX), 64'd1);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_pkt_done", 64'(pkt_done), 64'd0);
    rst = 1'b0;
    r = cyc;
    push_pkt(vecs[0]);

    // First packet: start delay, bit-run widths, snapshot isolation, packet length.
    wait_tx_low(5000, t0);
    check("first_start_cycle", 64'(t0 - r), 64'd4096);
    check("busy_at_start", 64'(busy), 64'd1);
    for (int k = 0; k < 9; k++) begin
      lvl = int'(TX);
      len = 1;
      @(negedge clk);
      while (int'(TX) == lvl && len < 200) begin
        len++;
        @(negedge clk);
      end
      check($sformatf("run%0d_len", k), 64'(len), 64'(run_exp[k]));
    end
    while (cyc < t0 + 350) @(negedge clk);
    apply_inputs(vecs[1]);
    push_pkt(vecs[1]);
    wait_done(2000, td);
    check("pkt_done_latency", 64'(td - t0), 64'd1280);
    check("busy_low_at_done", 64'(busy), 64'd0);
    @(negedge clk);
    check("pkt_done_one_cycle", 64'(pkt_done), 64'd0);
    check("queue_after_pkt0", 64'(exp_q.size()), 64'd8);

    // Second packet carries the updated battery value.
    wait_tx_low(5000, t1);
    check("packet_period", 64'(t1 - t0), 64'd4096);
    wait_done(2000, td);
    check("queue_after_pkt1", 64'(exp_q.size()), 64'd0);

    // Reset during DATA of byte 4 aborts the packet.
    apply_inputs(vecs[2]);
    push_pkt(vecs[2]);
    wait_tx_low(5000, t2);
    while (cyc < t2 + 700) @(negedge clk);
    dc = done_cnt;
    #2 rst = 1'b1;
    #1;
    check("abort_tx_async", 64'(TX), 64'd1);
    check("abort_busy_async", 64'(busy), 64'd0);
    repeat (3) @(negedge clk);
    check("abort_no_pkt_done", 64'(done_cnt - dc), 64'd0);
    check("abort_bytes_received", 64'(exp_q.size()), 64'd4);
    exp_q.delete();
    push_pkt(vecs[2]);
    rst = 1'b0;
    r = cyc;
    wait_tx_low(5000, t2);
    check("restart_start_cycle", 64'(t2 - r), 64'd4096);
    wait_done(2000, td);
    check("restart_pkt_latency", 64'(td - t2), 64'd1280);
    check("queue_after_restart", 64'(exp_q.size()), 64'd0);

    // Dropped triggers: 1024-cycle period shorter than the 1280-cycle packet.
    sel = 1'b1;
    apply_inputs(vecs[3]);
    push_pkt(vecs[3]);
    push_pkt(vecs[3]);
    @(negedge clk);
    rst2 = 1'b0;
    prev = 0;
    for (int c = 1; c <= 4400; c++) begin
      @(negedge clk);
      if (busy2 === 1'b1 && prev == 0) starts.push_back(c);
      prev = (busy2 === 1'b1) ? 1 : 0;
    end
    check("drop_num_starts", 64'(starts.size()), 64'd2);
    check("drop_start0", 64'((starts.size() > 0) ? starts[0] : -1), 64'd1024);
    check("drop_start1", 64'((starts.size() > 1) ? starts[1] : -1), 64'd3072);
    check("drop_pkt_done_count", 64'(done2_cnt), 64'd2);
    check("drop_queue_empty", 64'(exp_q.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
